irq_controller: RTL
===================

Name: irq_controller

Overview:
- Interrupt source side of the CPU's irq / reset_irq handshake.
- Synchronises and edge-detects up to NUM_SOURCES external interrupt lines, latches them as pending, and applies a software-writable enable mask.
- Selects the highest-priority source, presents irq plus a 16-bit handler vector to the control path, and retires the source when the control path pulses reset_irq.

Parameters:
- NUM_SOURCES, 8, number of interrupt inputs (1..16).
- VECTOR_BASE, 16'hFF00, handler address of source 0.
- VECTOR_STRIDE, 16'h0010, address spacing between consecutive source handlers.
- MASK_RESET, all ones, reset value of the enable mask (width NUM_SOURCES).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- irq_src  in  NUM_SOURCES  raw asynchronous interrupt lines; a rising edge requests service.
- mask_write  in  1  when high, load mask_data into the enable mask at the clock edge.
- mask_data  in  NUM_SOURCES  new enable mask; 1 = enabled.
- reset_irq  in  1  acknowledge from the control path; single-cycle pulse.
- irq  out  1  interrupt request to the control path (registered).
- irq_vector  out  16  handler PC for the request currently being presented (registered).
- irq_id  out  4  index of the request currently being presented.
- mask  out  NUM_SOURCES  current enable mask readback.
- pending  out  NUM_SOURCES  current pending latches readback.

Behaviour:
- Reset (async, reset=0):
  - sync stages, edge history and pending are cleared to 0; mask = MASK_RESET.
  - irq=0, irq_vector=0, irq_id=0; FSM = IDLE.
  - Reset asserted mid-handshake abandons the request; no ack is required afterwards.
- Synchroniser: each irq_src bit passes through 2 flops (s1, s2), then a history flop (s2_d).
- Edge detect: edge[i] = s2[i] & ~s2_d[i].
- Latency:
  - A rise captured by s1 at edge k makes pending[i] visible after edge k+2.
  - irq rises after edge k+3 if the FSM is IDLE and the source is enabled.
- Pending: set by edge[i] regardless of mask; cleared only by acknowledge of that index. A simultaneous set and clear on the same index leaves it set, so the new edge is not lost.
- Mask: written on mask_write. The mask gates selection only; masked sources stay pending and are requested once unmasked.
- Priority: the lowest index among (pending & mask) wins.
- Vector: irq_vector = VECTOR_BASE + idx*VECTOR_STRIDE, 16-bit, wrapping modulo 2^16.
- FSM states:
  - IDLE: irq=0. If (pending & mask) != 0, latch the winning idx into irq_id and irq_vector, go to ASSERT.
  - ASSERT: irq=1; irq_id and irq_vector held constant. Masking or new higher-priority pendings do NOT change the committed request. On reset_irq=1: clear pending[irq_id], go to HOLDOFF.
  - HOLDOFF: irq=0 for exactly one cycle, then go to IDLE. This guarantees that when the control path returns to its reset state after the ack it samples irq=0 and executes at least one handler instruction before any re-entry.
- reset_irq while in IDLE or HOLDOFF is ignored; no pending bits change.
- irq_vector and irq_id keep their last values outside ASSERT (no glitching).
- Simultaneous edges on several sources all latch as pending; they are served one per handshake in priority order, with at least 2 irq-low cycles between consecutive requests (HOLDOFF + IDLE).
- A repeated edge on a source that is already pending (and not being acked that cycle) is absorbed; there is no counting.

Test Plan:
- Reset with MASK_RESET=8'hFF; pulse irq_src[3] -> pending=8'h08 after 3 edges, irq=1 one edge later, irq_id=3, irq_vector=16'hFF30.
- In ASSERT, one-cycle reset_irq -> next cycle irq=0, pending[3]=0; irq stays 0 for at least 2 cycles; a stray reset_irq in IDLE changes nothing.
- Raise irq_src[5] and irq_src[1] on the same cycle -> first request irq_id=1 (vector FF10); after ack and HOLDOFF, second request irq_id=5 (vector FF50).
- mask_write with mask_data=8'hFE, then pulse src[0] -> pending=8'h01 but irq stays 0; write mask 8'hFF -> irq=1, irq_id=0, vector FF00.
- While presenting idx 4, pulse src[0] and mask out bit 4 -> irq_id stays 4 until ack; src[0] is served next.
- Edge on src[2] in the same cycle as the ack of idx 2 -> pending[2] stays 1 and is re-requested after HOLDOFF. Separately, drop reset to 0 while in ASSERT -> irq=0 and pending=0 immediately.

Source files
------------

// File: rtl/irq_controller.sv
// Interrupt source for the CPU irq / reset_irq handshake. External lines are synchronised
// and edge-detected, then latched as pending. The lowest enabled index is presented until it is acknowledged.
module irq_controller #(
    parameter int                     NUM_SOURCES   = 8,
    parameter logic [15:0]            VECTOR_BASE   = 16'hFF00,
    parameter logic [15:0]            VECTOR_STRIDE = 16'h0010,
    parameter logic [NUM_SOURCES-1:0] MASK_RESET    = '1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_SOURCES-1:0] irq_src,
    input  logic                   mask_write,
    input  logic [NUM_SOURCES-1:0] mask_data,
    input  logic                   reset_irq,
    output logic                   irq,
    output logic [15:0]            irq_vector,
    output logic [3:0]             irq_id,
    output logic [NUM_SOURCES-1:0] mask,
    output logic [NUM_SOURCES-1:0] pending,
    output logic [1:0]             fsm_state
);

    // Handshake: irq stays high from the cycle a request is committed until the
    // control path pulses reset_irq for one cycle. The request is then retired,
    // and irq is held low for at least two cycles before the next one.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic                   load;
    logic                   ack;

    logic [NUM_SOURCES-1:0] s1;
    logic [NUM_SOURCES-1:0] s2;
    logic [NUM_SOURCES-1:0] s2_d;
    logic [NUM_SOURCES-1:0] rise;
    logic [NUM_SOURCES-1:0] request;
    logic [NUM_SOURCES-1:0] clear;
    logic [NUM_SOURCES-1:0] pending_next;

    logic                   win_valid;
    logic [3:0]             win_idx;
    logic [15:0]            win_vector;

    assign fsm_state = state;

    // Two-flop synchroniser followed by a history flop for edge detection.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1   <= '0;
            s2   <= '0;
            s2_d <= '0;
        end else begin
            s1   <= irq_src;
            s2   <= s1;
            s2_d <= s2;
        end
    end

    assign rise    = s2 & ~s2_d;
    assign request = pending & mask;

    // Lowest index wins, so the loop walks downwards and the last hit sticks.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = 4'd0;
        for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
            if (request[i]) begin
                win_valid = 1'b1;
                win_idx   = 4'(i);
            end
        end
    end

    assign win_vector = VECTOR_BASE + 16'(win_idx) * VECTOR_STRIDE;

    assign ack = (state == ASSERT) && reset_irq;

    always_comb begin
        clear = '0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            if (ack && (irq_id == 4'(i))) begin
                clear[i] = 1'b1;
            end
        end
    end

    // The set term is applied after the clear, so an edge that arrives in the same
    // cycle as its acknowledge is kept.
    assign pending_next = (pending & ~clear) | rise;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending <= '0;
            mask    <= MASK_RESET;
        end else begin
            pending <= pending_next;
            if (mask_write) begin
                mask <= mask_data;
            end
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (win_valid) begin
                    state_next = ASSERT;
                    load       = 1'b1;
                end
            end
            ASSERT: begin
                if (reset_irq) begin
                    state_next = HOLDOFF;
                end
            end
            HOLDOFF: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // irq_id and irq_vector load only on commit, so they hold steady during ASSERT and keep their values afterwards.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            irq        <= 1'b0;
            irq_id     <= 4'd0;
            irq_vector <= 16'd0;
        end else begin
            state <= state_next;
            irq   <= (state_next == ASSERT);
            if (load) begin
                irq_id     <= win_idx;
                irq_vector <= win_vector;
            end
        end
    end

endmodule
